// File: rtl/shift_seq_unit_pkg.sv
// Shared definitions for the iterative shift unit: op encodings, FSM states
// and the default shift-amount width.
package shift_seq_unit_pkg;

    localparam int XLEN_DEF = 32;
    localparam int SHAMT_W  = $clog2(XLEN_DEF);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift step: moves data by 0..STEP bits left, right
// with zero fill, or right with sign fill.
module shift_step #(
    parameter int XLEN = 32,
    parameter int STEP = 8
) (
    input  logic [XLEN-1:0]            data,
    input  logic [$clog2(STEP+1)-1:0]  amount,
    input  logic                       right,
    input  logic                       arith,
    output logic [XLEN-1:0]            result
);

    logic signed [XLEN-1:0] sdata;

    assign sdata = data;

    always_comb begin
        if (!right) begin
            result = data << amount;
        end else if (arith) begin
            result = sdata >>> amount;
        end else begin
            result = data >> amount;
        end
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative shifter: accepts one request, shifts at most STEP bits per clock,
// then presents the result until the consumer takes it.
module shift_seq_unit
    import shift_seq_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int STEP  = 8,
    parameter int TAG_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_op,
    input  logic [XLEN-1:0]           in_data,
    input  logic [$clog2(XLEN)-1:0]   in_shamt,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      busy
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(STEP + 1);

    state_t             state;
    logic [XLEN-1:0]    acc;
    logic [SW-1:0]      rem;
    logic [TAG_W-1:0]   tag_q;
    logic               right_q;
    logic               arith_q;
    logic [CW-1:0]      chunk;
    logic [SW-1:0]      chunk_ext;
    logic [XLEN-1:0]    step_res;

    function automatic logic [CW-1:0] chunk_of(input logic [SW-1:0] r);
        if (int'(r) > STEP) begin
            return CW'(STEP);
        end
        return CW'(r);
    endfunction

    assign chunk     = chunk_of(rem);
    assign chunk_ext = SW'(chunk);

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .data   (acc),
        .amount (chunk),
        .right  (right_q),
        .arith  (arith_q),
        .result (step_res)
    );

    // Operand, op and tag registers carry no reset; only control and the
    // visible result/tag are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rem       <= '0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rem       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc      <= in_data;
                        right_q  <= (in_op == OP_SRL) || (in_op == OP_SRA);
                        arith_q  <= (in_op == OP_SRA);
                        tag_q    <= in_tag;
                        rem      <= in_shamt;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_shamt == '0) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_tag   <= in_tag;
                        end else begin
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    acc <= step_res;
                    rem <= rem - chunk_ext;
                    if (rem == chunk_ext) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_data  <= step_res;
                        out_tag   <= tag_q;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
Iterative multi-cycle shift execution unit for the integer pipeline. It accepts one shift request (operand, amount, op, tag) over a valid/ready handshake. It shifts the operand by at most STEP bits per clock and returns the result over a second valid/ready handshake. It is the area-saving counterpart to the full single-cycle 32-bit shifter, for configurations that trade latency for logic.

Parameters:
XLEN, 32, operand/result width.
STEP, 8, maximum shift distance per cycle; power of two, 1..XLEN.
TAG_W, 5, width of the opaque tag passed from request to response.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  abort any in-flight request.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request.
in_op  in  2  op[0]=right, op[1]=arithmetic; 00 SLL, 01 SRL, 11 SRA, 10 treated as SLL.
in_data  in  XLEN  operand.
in_shamt  in  $clog2(XLEN)  shift amount, unsigned.
in_tag  in  TAG_W  request tag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_data  out  XLEN  shifted result.
out_tag  out  TAG_W  tag of the request that produced out_data.
busy  out  1  high in BUSY or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), fixed.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_tag=0, busy=0, internal remaining-count=0. in_ready is 1 from the first cycle after reset.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). No other outputs depend combinationally on inputs.
- Accept: on an edge where state==IDLE, in_valid=1, and flush=0:
  - latch data, op, tag;
  - rem = in_shamt;
  - if in_shamt==0, go to DONE; otherwise go to BUSY.
- BUSY, each edge:
  - chunk = min(rem, STEP);
  - data shifts by chunk: left (zero fill) for SLL, right (zero fill) for SRL, right (fill with the latched bit XLEN-1) for SRA;
  - rem -= chunk;
  - when rem reaches 0 on this edge, go to DONE.
- Latency from accept edge to out_valid: 1 cycle when shamt==0, otherwise 1+ceil(shamt/STEP) cycles. For XLEN=32, STEP=8 the maximum is 5.
- DONE: out_data and out_tag are held stable while out_ready=0. On an edge with out_ready=1, go to IDLE. A new request cannot be accepted in the same cycle the result is taken.
- flush: when 1 on an edge, go to IDLE from any state and set out_valid=0. The in-flight result is discarded and out_data is unchanged. flush together with in_valid in IDLE means no accept.
- rst has priority over flush and over any handshake. Reset during BUSY/DONE drops the request with no response.
- The SRA sign is taken from the operand latched at accept. It is preserved across all steps, so a shamt of XLEN-1 yields all-sign.
- in_* are sampled only on the accept edge; changes at any other time are ignored.

Decomposition:
- Shared package: op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11), state enum, and SHAMT_W=$clog2(XLEN).
- One sub-module, shift_step: purely combinational. It takes data, amount (0..STEP), right, and arith, and returns data shifted by amount. Instantiated once inside the FSM datapath.

Test Plan:
- STEP=8, SLL 0x0000_0001 by 31 -> out_data=0x8000_0000, out_valid exactly 5 cycles after accept, tag echoed.
- SRA 0x8000_00F0 by 4 -> 0xF800_000F at latency 2; SRL same operand by 4 -> 0x0800_000F.
- shamt=0, SRA 0xDEAD_BEEF -> 0xDEAD_BEEF at latency 1; SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_data/out_tag stable, in_ready=0, in_valid ignored. Then out_ready=1 -> IDLE next cycle, and the next request is accepted one cycle later.
- flush asserted in the second BUSY cycle of SLL by 20 -> out_valid never rises for that tag, in_ready=1 next cycle. flush with in_valid in IDLE -> no accept.
- rst asserted mid-BUSY -> all outputs return to reset values next cycle. A subsequent SRL 0xFFFF_FFFF by 8 -> 0x00FF_FFFF at latency 2.
